qeciphy_tx_link_sequencer: RTL and testbench
============================================

// Module: qeciphy_tx_link_sequencer
// PURPOSE
//  Bring-up/shutdown sequencer driving link_enable/data_enable of the QECIPHY TX controller.
//  Enables the link (idle + boundaries), lets the far end lock for a fixed number of frames,
//  waits for remote-ready, and only then grants data. Drains back to idle before turning off.
//  Counts time in frames via FAW boundary pulses; detects remote lock timeout.
// PARAMETERS
//  SETTLE_FRAMES   16    frames of link-only (idle+boundaries) before remote-ready is honoured; >=1
//  TIMEOUT_FRAMES  1024  frames allowed in WAIT_REMOTE before FAULT; >=1
//  DRAIN_FRAMES    2     frames of link-only after data is revoked before leaving DRAIN; >=1
// PORTS
//  clk_i            in   1  TX clock
//  rst_n_i          in   1  asynchronous active-low reset
//  faw_boundary_i   in   1  one-cycle pulse per frame (FAW boundary)
//  phy_ready_i      in   1  transceiver TX path ready (level)
//  enable_req_i     in   1  software link enable request (level)
//  remote_ready_i   in   1  far-end RX aligned (level, already synchronised)
//  data_req_i       in   1  user has data to send (level)
//  link_enable_o    out  1  to TX controller link_enable
//  data_enable_o    out  1  to TX controller data_enable
//  state_o          out  3  current state encoding (status/debug)
//  fault_pulse_o    out  1  one-cycle pulse on entry to FAULT
// BEHAVIOUR
//  Reset (async assert, sync-to-clk deassert handled upstream): state OFF, all outputs 0, counter 0.
//  States/encoding: OFF=0 SETTLE=1 WAIT_REMOTE=2 READY=3 DATA=4 DRAIN=5 FAULT=6; 7 unused -> OFF.
//  Global priority 1: !phy_ready_i in any state except OFF -> OFF next cycle (no drain).
//  OFF:         enable_req_i && phy_ready_i -> SETTLE.
//  SETTLE:      !enable_req_i -> OFF; faw pulse with cnt==SETTLE_FRAMES-1 -> WAIT_REMOTE.
//  WAIT_REMOTE: !enable_req_i -> OFF; remote_ready_i -> READY (wins over timeout same cycle);
//               else faw pulse with cnt==TIMEOUT_FRAMES-1 -> FAULT.
//  READY:       !enable_req_i -> OFF; !remote_ready_i -> WAIT_REMOTE; data_req_i -> DATA.
//  DATA:        !enable_req_i | !remote_ready_i | !data_req_i -> DRAIN.
//  DRAIN:       faw pulse with cnt==DRAIN_FRAMES-1 -> OFF if !enable_req_i, else READY if
//               remote_ready_i, else WAIT_REMOTE. data_req_i ignored while draining.
//  FAULT:       hold until !enable_req_i -> OFF (no auto-retry).
//  Frame counter: cleared on every state change; increments on faw_boundary_i only in
//   SETTLE/WAIT_REMOTE/DRAIN; width $clog2(max param)+1; never wraps (exit precedes overflow).
//   A faw pulse in the same cycle as state entry is not counted.
//  Outputs registered, decoded from next state (valid in same cycle as state_o):
//   link_enable_o=1 in SETTLE/WAIT_REMOTE/READY/DATA/DRAIN; data_enable_o=1 in DATA only;
//   fault_pulse_o=1 for exactly the first cycle in FAULT. Latency input->output: 1 clk.
//  Invariant: data_enable_o=1 implies link_enable_o=1.
// STRUCTURE
//  qeciphy_pkg: typedef enum logic [2:0] tx_seq_state_t (encodings above).
//  Sub-module qeciphy_frame_counter: clear/enable/faw-pulse counter with terminal-count compare;
//   one instance, retargeted per state via muxed terminal value.
// TESTING
//  1 SETTLE=4, phy_ready=1, remote_ready=1, enable_req 0->1 -> link_enable_o=1 next clk;
//    READY one clk after 4th faw pulse; data_enable_o stays 0.
//  2 In READY, data_req 0->1 -> DATA, data_enable_o=1 next clk; data_req->0 -> data_enable_o=0
//    next clk, link_enable_o held; READY one clk after 2nd faw pulse (DRAIN=2).
//  3 TIMEOUT=8, remote_ready=0 -> FAULT after 8th WAIT_REMOTE faw pulse, fault_pulse_o one clk,
//    link_enable_o=0; enable_req->0 -> OFF, state_o=0.
//  4 In DATA, phy_ready 1->0 -> next clk OFF, both enables 0, no DRAIN state visited.
//  5 remote_ready rises same clk as final timeout faw pulse -> READY, fault_pulse_o stays 0.
//  6 rst_n_i asserted mid-DATA between clock edges -> outputs 0 immediately, state_o=0.

Source files
------------

// File: rtl/qeciphy_pkg.sv
// qeciphy_pkg: shared types and helpers for the QECIPHY TX link sequencer
package qeciphy_pkg;
  typedef enum logic [2:0] {
    ST_OFF         = 3'd0,
    ST_SETTLE      = 3'd1,
    ST_WAIT_REMOTE = 3'd2,
    ST_READY       = 3'd3,
    ST_DATA        = 3'd4,
    ST_DRAIN       = 3'd5,
    ST_FAULT       = 3'd6
  } tx_seq_state_t;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/qeciphy_frame_counter.sv
// qeciphy_frame_counter: frame counter with clear, FAW-gated increment and terminal-count strobe
//   clk_i/rst_n_i clock and async active-low reset; clear_i zeroes the count;
//   enable_i gates counting of faw_i pulses; term_i is the terminal value;
//   tc_o pulses when a counted faw pulse lands on the terminal value.
module qeciphy_frame_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic         faw_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt <= '0;
    else cnt <= clear_i ? '0 : (enable_i && faw_i) ? cnt + W'(1) : cnt;
  assign tc_o = enable_i && faw_i && (cnt == term_i);
endmodule

// File: rtl/qeciphy_tx_link_sequencer.sv
// qeciphy_tx_link_sequencer: bring-up/shutdown sequencer for the TX link and data enables
//   inputs:  clk_i, rst_n_i (async active-low), faw_boundary_i (frame pulse), phy_ready_i,
//            enable_req_i, remote_ready_i, data_req_i
//   outputs: link_enable_o, data_enable_o, state_o[2:0], fault_pulse_o (all registered)
module qeciphy_tx_link_sequencer
  import qeciphy_pkg::*;
#(
  parameter int SETTLE_FRAMES  = 16,
  parameter int TIMEOUT_FRAMES = 1024,
  parameter int DRAIN_FRAMES   = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       faw_boundary_i,
  input  logic       phy_ready_i,
  input  logic       enable_req_i,
  input  logic       remote_ready_i,
  input  logic       data_req_i,
  output logic       link_enable_o,
  output logic       data_enable_o,
  output logic [2:0] state_o,
  output logic       fault_pulse_o
);
  localparam int CW = $clog2(max3(SETTLE_FRAMES, TIMEOUT_FRAMES, DRAIN_FRAMES)) + 1;
  tx_seq_state_t state, nxt;
  logic [CW-1:0] term;
  logic tc, counting;
  assign counting = state inside {ST_SETTLE, ST_WAIT_REMOTE, ST_DRAIN};
  // One counter serves every timed state; only its terminal value changes.
  assign term = (state == ST_SETTLE)      ? CW'(SETTLE_FRAMES - 1)  :
                (state == ST_WAIT_REMOTE) ? CW'(TIMEOUT_FRAMES - 1) :
                                            CW'(DRAIN_FRAMES - 1);
  assign state_o = state;
  qeciphy_frame_counter #(.W(CW)) u_cnt (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (nxt != state),
    .enable_i (counting),
    .faw_i    (faw_boundary_i),
    .term_i   (term),
    .tc_o     (tc)
  );
  always_comb begin
    nxt = ST_OFF;
    if (state == ST_OFF || phy_ready_i)
      case (state)
        ST_OFF:         nxt = (enable_req_i && phy_ready_i) ? ST_SETTLE : ST_OFF;
        ST_SETTLE:      nxt = !enable_req_i ? ST_OFF : tc ? ST_WAIT_REMOTE : ST_SETTLE;
        ST_WAIT_REMOTE: nxt = !enable_req_i ? ST_OFF : remote_ready_i ? ST_READY :
                              tc ? ST_FAULT : ST_WAIT_REMOTE;
        ST_READY:       nxt = !enable_req_i ? ST_OFF : !remote_ready_i ? ST_WAIT_REMOTE :
                              data_req_i ? ST_DATA : ST_READY;
        ST_DATA:        nxt = (enable_req_i && remote_ready_i && data_req_i) ? ST_DATA : ST_DRAIN;
        ST_DRAIN:       nxt = !tc ? ST_DRAIN : !enable_req_i ? ST_OFF :
                              remote_ready_i ? ST_READY : ST_WAIT_REMOTE;
        ST_FAULT:       nxt = enable_req_i ? ST_FAULT : ST_OFF;
        default:        nxt = ST_OFF;
      endcase
  end
  // Outputs are decoded from the next state so they line up with state_o.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state         <= ST_OFF;
      link_enable_o <= 1'b0;
      data_enable_o <= 1'b0;
      fault_pulse_o <= 1'b0;
    end else begin
      state         <= nxt;
      link_enable_o <= nxt inside {ST_SETTLE, ST_WAIT_REMOTE, ST_READY, ST_DATA, ST_DRAIN};
      data_enable_o <= nxt == ST_DATA;
      fault_pulse_o <= (nxt == ST_FAULT) && (state != ST_FAULT);
    end
endmodule

// File: tb/tb_qeciphy_tx_link_sequencer.sv
// tb_qeciphy_tx_link_sequencer: directed and randomized checks against a behavioural model
module tb_qeciphy_tx_link_sequencer;
  localparam int SF = 4, TF = 8, DF = 2;
  logic clk = 0, rst_n = 0;
  logic faw = 0, phy = 0, en = 0, remote = 0, dreq = 0;
  logic link_en, data_en, fault_p;
  logic [2:0] st;
  int vec = 0, errs = 0;
  int ms = 0, frames = 0;
  bit mfp = 0;
  always #5 clk = ~clk;
  qeciphy_tx_link_sequencer #(.SETTLE_FRAMES(SF), .TIMEOUT_FRAMES(TF), .DRAIN_FRAMES(DF)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .faw_boundary_i(faw), .phy_ready_i(phy),
    .enable_req_i(en), .remote_ready_i(remote), .data_req_i(dreq),
    .link_enable_o(link_en), .data_enable_o(data_en), .state_o(st), .fault_pulse_o(fault_p)
  );
  task automatic cmp(input string n, input int act, input int exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  function automatic int frames_needed(input int s);
    return s == 1 ? SF : s == 2 ? TF : DF;
  endfunction
  // Reference: state number plus frames seen since entering that state.
  always @(posedge clk or negedge rst_n) begin
    int ns;
    bit last_frame;
    if (!rst_n) begin
      ms = 0; frames = 0; mfp = 0;
    end else begin
      last_frame = faw && (frames + 1 == frames_needed(ms));
      ns = ms;
      if (ms != 0 && !phy) ns = 0;
      else if (ms == 0) begin if (en && phy) ns = 1; end
      else if (ms == 1) ns = !en ? 0 : last_frame ? 2 : 1;
      else if (ms == 2) ns = !en ? 0 : remote ? 3 : last_frame ? 6 : 2;
      else if (ms == 3) ns = !en ? 0 : !remote ? 2 : dreq ? 4 : 3;
      else if (ms == 4) ns = (en && remote && dreq) ? 4 : 5;
      else if (ms == 5) ns = !last_frame ? 5 : !en ? 0 : remote ? 3 : 2;
      else if (ms == 6) ns = en ? 6 : 0;
      mfp = (ns == 6) && (ms != 6);
      if (ns != ms) frames = 0;
      else if (faw && (ms == 1 || ms == 2 || ms == 5)) frames++;
      ms = ns;
    end
  end
  always @(negedge clk) if (rst_n) begin
    cmp("state", st, ms);
    cmp("link_enable", link_en, (ms >= 1 && ms <= 5) ? 1 : 0);
    cmp("data_enable", data_en, ms == 4 ? 1 : 0);
    cmp("fault_pulse", fault_p, mfp);
    cmp("invariant", (data_en && !link_en) ? 1 : 0, 0);
  end
  task automatic step(input bit f);
    faw = f;
    @(negedge clk);
    faw = 0;
  endtask
  task automatic frames_n(input int n);
    for (int i = 0; i < n; i++) step(1);
  endtask
  initial begin
    #12;
    cmp("reset_state", st, 0);
    cmp("reset_link", link_en, 0);
    cmp("reset_data", data_en, 0);
    cmp("reset_fault", fault_p, 0);
    @(negedge clk);
    rst_n = 1;
    phy = 1; remote = 1;
    step(0); step(0);
    en = 1;
    step(0);
    cmp("t1_settle", st, 1);
    cmp("t1_link", link_en, 1);
    frames_n(3);
    cmp("t1_still_settle", st, 1);
    step(1);
    cmp("t1_wait", st, 2);
    step(0);
    cmp("t1_ready", st, 3);
    cmp("t1_no_data", data_en, 0);
    dreq = 1; step(0);
    cmp("t2_data", st, 4);
    cmp("t2_data_en", data_en, 1);
    dreq = 0; step(0);
    cmp("t2_drain", st, 5);
    cmp("t2_drain_data", data_en, 0);
    cmp("t2_drain_link", link_en, 1);
    step(1);
    cmp("t2_drain_hold", st, 5);
    step(1);
    cmp("t2_back_ready", st, 3);
    remote = 0; step(0);
    cmp("t3_wait", st, 2);
    frames_n(7);
    cmp("t3_wait_hold", st, 2);
    step(1);
    cmp("t3_fault", st, 6);
    cmp("t3_fault_pulse", fault_p, 1);
    cmp("t3_fault_link", link_en, 0);
    step(0);
    cmp("t3_pulse_once", fault_p, 0);
    en = 0; step(0);
    cmp("t3_off", st, 0);
    remote = 1; en = 1; step(0); frames_n(SF); step(0);
    dreq = 1; step(0);
    cmp("t4_data", st, 4);
    phy = 0; step(0);
    cmp("t4_off", st, 0);
    cmp("t4_link", link_en, 0);
    cmp("t4_data_en", data_en, 0);
    phy = 1; remote = 0; dreq = 0; step(0); frames_n(SF);
    cmp("t5_wait", st, 2);
    frames_n(TF - 1);
    remote = 1; step(1);
    cmp("t5_ready", st, 3);
    cmp("t5_no_fault", fault_p, 0);
    dreq = 1; step(0);
    cmp("t6_data", st, 4);
    #3 rst_n = 0;
    #1;
    cmp("t6_state", st, 0);
    cmp("t6_link", link_en, 0);
    cmp("t6_data_en", data_en, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(59) == 0) phy = !phy;
      if ($urandom_range(39) == 0) en = !en;
      if ($urandom_range(24) == 0) remote = !remote;
      if ($urandom_range(9) == 0) dreq = !dreq;
      step($urandom_range(2) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
